int_divider_seq: RTL and testbench

Self-contained parameterised sequential integer divider: controller and datapath in one block. Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor using restoring shift/subtract, one quotient bit per clock. Supports unsigned and optional two's-complement signed mode. Provides a start/busy/done handshake and divide-by-zero error reporting, and replaces the fixed 4-bit divider datapath/controller pair in new designs.

---
 rtl/int_divider_seq.sv | 126 ++++++++++++
 tb/tb_int_divider_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/int_divider_seq.sv
// Sequential restoring integer divider, one quotient bit per clock.
// Unsigned by default; optional two's-complement mode divides magnitudes
// and applies the signs in a final fix-up cycle.
//
// state | meaning
// IDLE  | waiting for start, results held
// DIV   | shift/subtract, one quotient bit per edge
// FIX   | apply signs to quotient and remainder
// DONE  | done pulse, return to IDLE
module int_divider_seq #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             error
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] y_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    counter;
    logic             sign_q;
    logic             sign_r;

    logic             signed_eff;
    logic             sd;
    logic             sv;
    logic [WIDTH-1:0] mag_dividend;
    logic [WIDTH-1:0] mag_divisor;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;

    // operand magnitudes; negating MIN gives 2^(WIDTH-1), which is correct as unsigned
    assign signed_eff   = SIGNED_EN && signed_mode;
    assign sd           = signed_eff & dividend[WIDTH-1];
    assign sv           = signed_eff & divisor[WIDTH-1];
    assign mag_dividend = sd ? -dividend : dividend;
    assign mag_divisor  = sv ? -divisor : divisor;

    // partial remainder shifted left with the next dividend bit, then trial subtract;
    // the extra top bit of trial acts as the borrow
    assign r_shift = {r_reg, x_reg[WIDTH-1]};
    assign trial   = r_shift - {1'b0, y_reg};

    // controller and datapath; all outputs are registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            counter   <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            r_reg     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            error     <= 1'b1;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            error   <= 1'b0;
                            sign_q  <= sd ^ sv;
                            sign_r  <= sd;
                            x_reg   <= mag_dividend;
                            y_reg   <= mag_divisor;
                            r_reg   <= '0;
                            counter <= CW'(WIDTH);
                            state   <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (!trial[WIDTH]) begin
                        r_reg <= trial[WIDTH-1:0];
                        x_reg <= {x_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        r_reg <= r_shift[WIDTH-1:0];
                        x_reg <= {x_reg[WIDTH-2:0], 1'b0};
                    end
                    counter <= counter - CW'(1);
                    if (counter == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= sign_q ? -x_reg : x_reg;
                    remainder <= sign_r ? -r_reg : r_reg;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_divider_seq.sv
// Bench for int_divider_seq: directed cases plus randomized operations checked
// against an arithmetic reference model (native / and % on integers).
module tb_int_divider_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       signed_mode;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy, done, error;
    logic [7:0] quotient, remainder;
    logic       busy_u, done_u, error_u;
    logic [7:0] quotient_u, remainder_u;

    int n_checks = 0;
    int n_errors = 0;

    int_divider_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .error(error)
    );

    int_divider_seq #(.WIDTH(8), .SIGNED_EN(1'b0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .dividend(dividend), .divisor(divisor),
        .busy(busy_u), .done(done_u), .quotient(quotient_u), .remainder(remainder_u),
        .error(error_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference: quotient truncates toward zero, remainder follows dividend sign
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic sm,
                         input bit sen, output logic [7:0] q, output logic [7:0] r,
                         output logic e);
        int sa, sb, iq, ir;
        if (b == 8'd0) begin
            q = 8'hFF; r = a; e = 1'b1;
        end else if (sm && sen) begin
            sa = {{24{a[7]}}, a};
            sb = {{24{b[7]}}, b};
            iq = sa / sb;
            ir = sa % sb;
            q = iq[7:0]; r = ir[7:0]; e = 1'b0;
        end else begin
            iq = int'(a) / int'(b);
            ir = int'(a) % int'(b);
            q = iq[7:0]; r = ir[7:0]; e = 1'b0;
        end
    endtask

    // call #1 after a posedge with both DUTs idle; returns the same way
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                          input string tag);
        int lat;
        logic [7:0] eq, er, equ, eru;
        logic ee, eeu;
        model(a, b, sm, 1'b1, eq, er, ee);
        model(a, b, sm, 1'b0, equ, eru, eeu);
        dividend = a; divisor = b; signed_mode = sm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = ~a; divisor = ~b;
        chk({tag, " busy"}, busy, 1);
        lat = 0;
        while (!done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, (b == 8'd0) ? 0 : 9);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " error"}, error, ee);
        chk({tag, " quotient_u"}, quotient_u, equ);
        chk({tag, " remainder_u"}, remainder_u, eru);
        chk({tag, " error_u"}, error_u, eeu);
        @(posedge clk); #1;
        chk({tag, " done falls"}, done, 0);
        chk({tag, " busy falls"}, busy, 0);
    endtask

    initial begin
        int lat, ndone;
        logic [7:0] ra, rb;
        rst = 1'b0; start = 1'b0; signed_mode = 1'b0; dividend = 8'd0; divisor = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset quotient", quotient, 0);
        chk("reset remainder", remainder, 0);
        chk("reset error", error, 0);
        @(posedge clk); #1;

        run_op(8'd100, 8'd7, 1'b0, "u100/7");
        chk("u100/7 q const", quotient, 8'h0E);
        run_op(8'h9C, 8'h07, 1'b1, "s-100/7");
        chk("s-100/7 q const", quotient, 8'hF2);
        chk("s-100/7 r const", remainder, 8'hFE);
        chk("nosigned 0x9C/7 q", quotient_u, 8'd22);
        chk("nosigned 0x9C/7 r", remainder_u, 8'd2);
        run_op(8'd100, 8'hF9, 1'b1, "s100/-7");
        chk("s100/-7 r const", remainder, 8'h02);
        run_op(8'h80, 8'hFF, 1'b1, "smin/-1");
        chk("smin/-1 q const", quotient, 8'h80);
        run_op(8'd55, 8'd0, 1'b0, "div0");
        chk("div0 q const", quotient, 8'hFF);
        chk("div0 r const", remainder, 8'h37);
        run_op(8'd9, 8'd3, 1'b0, "after div0");
        chk("after div0 error const", error, 0);

        // start held high through a whole operation: only the first is taken
        dividend = 8'd200; divisor = 8'd13; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        dividend = 8'd9; divisor = 8'd3;
        lat = 0;
        while (!done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("held start latency", lat, 9);
        chk("held start q", quotient, 8'd15);
        chk("held start r", remainder, 8'd5);
        @(posedge clk); #1;
        chk("held start idle after done", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("held start next accept", busy, 1);
        lat = 0;
        while (!done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("second op q", quotient, 8'd3);
        chk("second op r", remainder, 8'd0);
        @(posedge clk); #1;

        // reset during the 4th DIV cycle aborts without a done pulse
        dividend = 8'd255; divisor = 8'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort quotient", quotient, 0);
        chk("abort remainder", remainder, 0);
        chk("abort error", error, 0);
        ndone = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort no done", ndone, 0);
        run_op(8'd255, 8'd1, 1'b0, "u255/1");

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            run_op(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
